intersection_phase_scheduler: RTL and testbench

Sequences a two-approach intersection: main street and side street, plus one pedestrian crossing. Drives the 3-bit light vectors for both approaches and the walk signal from a single Moore state machine with a shared phase timer. Main street rests on green by default. Side-street car-sensor demand and latched pedestrian requests pull the intersection through yellow and all-red clearance phases. This block sits above the per-approach LED drivers and is the only source of light commands.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/phase_timer.sv | 27 ++
 rtl/intersection_phase_scheduler.sv | 114 +++++++++++
 tb/tb_intersection_phase_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase scheduler.
//   phase_t      : 3-bit state encoding (code 7 is unused and treated as illegal)
//   LIGHT_*      : one-hot {red,yellow,green} lamp vectors for each approach
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    CLR_A    = 3'd2,
    PED_WALK = 3'd3,
    SIDE_GRN = 3'd4,
    SIDE_YEL = 3'd5,
    CLR_B    = 3'd6
  } phase_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Shared phase down-counter.
//   clk, reset : clock, async active-low reset (loads RST_VAL)
//   load       : load load_val this edge (phase entry)
//   load_val   : duration-1 of the phase being entered
//   value      : current count; holds at 0 once expired
//   done       : value == 0
module phase_timer #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              value <= RST_VAL;
    else if (load)           value <= load_val;
    else if (value != '0)    value <= value - 1'b1;
  end

  assign done = (value == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-approach intersection sequencer with one pedestrian crossing.
//   clk, reset   : clock, async active-low reset
//   ped_button   : pedestrian request pulse (latched into ped_pending)
//   side_sensor  : side-street car present, sampled only at decisions
//   main_lights  : {red,yellow,green} main street, registered
//   side_lights  : {red,yellow,green} side street, registered
//   walk         : pedestrian walk lamp, registered
//   ped_pending  : latched pedestrian request
//   phase        : current state code
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MAIN_MIN_GREEN = 8,
  parameter int SIDE_GREEN     = 4,
  parameter int YELLOW         = 2,
  parameter int ALL_RED        = 1,
  parameter int WALK           = 5,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_button,
  input  logic       side_sensor,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] MG_M1 = CNT_W'(MAIN_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] SG_M1 = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] YL_M1 = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_M1 = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WK_M1 = CNT_W'(WALK - 1);

  phase_t           state, state_nxt;
  logic             load, tmr_done;
  logic [CNT_W-1:0] load_val, tmr_val;

  function automatic logic [CNT_W-1:0] dur_m1(input phase_t p);
    case (p)
      MAIN_YEL, SIDE_YEL: dur_m1 = YL_M1;
      CLR_A, CLR_B:       dur_m1 = AR_M1;
      PED_WALK:           dur_m1 = WK_M1;
      SIDE_GRN:           dur_m1 = SG_M1;
      default:            dur_m1 = MG_M1;
    endcase
  endfunction

  // Next-state decision. Main green simply parks with the timer at 0
  // when nothing is waiting, so demand is taken on the very next edge.
  always_comb begin
    state_nxt = state;
    case (state)
      MAIN_GRN: if (tmr_done && (ped_pending || side_sensor)) state_nxt = MAIN_YEL;
      MAIN_YEL: if (tmr_done) state_nxt = CLR_A;
      // Once yellow has been shown the cycle is committed: with no ped
      // request we go to side green even if the car has left.
      CLR_A:    if (tmr_done) state_nxt = ped_pending ? PED_WALK : SIDE_GRN;
      PED_WALK: if (tmr_done) state_nxt = side_sensor ? SIDE_GRN : CLR_B;
      SIDE_GRN: if (tmr_done) state_nxt = SIDE_YEL;
      SIDE_YEL: if (tmr_done) state_nxt = CLR_B;
      CLR_B:    if (tmr_done) state_nxt = MAIN_GRN;
      default:  state_nxt = MAIN_GRN;
    endcase
  end

  // No phase ever transitions to itself, so any change of state is an entry.
  assign load     = (state_nxt != state);
  assign load_val = dur_m1(state_nxt);

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(MG_M1)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .value    (tmr_val),
    .done     (tmr_done)
  );

  // State, request latch and lamp registers. Lamps decode the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= MAIN_GRN;
      main_lights <= LIGHT_GREEN;
      side_lights <= LIGHT_RED;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state <= state_nxt;

      // Entering the walk phase serves the request and beats a new press.
      if (load && state_nxt == PED_WALK)       ped_pending <= 1'b0;
      else if (ped_button && state != PED_WALK) ped_pending <= 1'b1;

      main_lights <= LIGHT_RED;
      side_lights <= LIGHT_RED;
      walk        <= 1'b0;
      case (state_nxt)
        MAIN_GRN: main_lights <= LIGHT_GREEN;
        MAIN_YEL: main_lights <= LIGHT_YELLOW;
        SIDE_GRN: side_lights <= LIGHT_GREEN;
        SIDE_YEL: side_lights <= LIGHT_YELLOW;
        PED_WALK: walk        <= 1'b1;
        default:  ;
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler (default parameters).
// Cycle c is the clock period that ends at the c-th rising edge after
// reset is released; outputs are sampled on the falling edge within it.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       ped_button;
  logic       side_sensor;
  logic [2:0] main_lights, side_lights, phase;
  logic       walk, ped_pending;

  int chk  = 0;
  int pass = 0;

  intersection_phase_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .ped_button  (ped_button),
    .side_sensor (side_sensor),
    .main_lights (main_lights),
    .side_lights (side_lights),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  // Expected lamps for a phase code, straight from the light table.
  function automatic logic [2:0] exp_main(input int p);
    case (p)
      0:       exp_main = 3'b001;
      1:       exp_main = 3'b010;
      default: exp_main = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int p);
    case (p)
      4:       exp_side = 3'b001;
      5:       exp_side = 3'b010;
      default: exp_side = 3'b100;
    endcase
  endfunction

  // Safety invariant every cycle out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk++;
      if ((main_lights !== 3'b100 && side_lights !== 3'b100) ||
          (walk === 1'b1 && (main_lights !== 3'b100 || side_lights !== 3'b100)) ||
          !$onehot(main_lights) || !$onehot(side_lights))
        $display("FAIL safety t=%0t main=%b side=%b walk=%b", $time, main_lights, side_lights, walk);
      else pass++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Hold reset across two edges, release mid-cycle; returns at start of cycle 0.
  task automatic start();
    reset = 1'b0; ped_button = 1'b0; side_sensor = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ped_button = 1'b1; side_sensor = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk++; if (main_lights !== 3'b001) $display("FAIL reset_main got=%b exp=001", main_lights); else pass++;
    chk++; if (side_lights !== 3'b100) $display("FAIL reset_side got=%b exp=100", side_lights); else pass++;
    chk++; if (walk !== 1'b0)          $display("FAIL reset_walk got=%b exp=0", walk); else pass++;
    chk++; if (ped_pending !== 1'b0)   $display("FAIL reset_ped got=%b exp=0", ped_pending); else pass++;
    chk++; if (phase !== 3'd0)         $display("FAIL reset_phase got=%0d exp=0", phase); else pass++;
  endtask

  task automatic test_idle();
    start();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk++; if (phase !== 3'd0 || main_lights !== 3'b001 || side_lights !== 3'b100 || walk !== 1'b0)
        $display("FAIL idle c=%0d phase=%0d main=%b side=%b walk=%b exp 0/001/100/0", c, phase, main_lights, side_lights, walk);
      else pass++;
      next_cycle();
    end
  endtask

  task automatic test_side_demand();
    int m, e;
    start();
    side_sensor = 1'b1;
    for (int c = 0; c < 40; c++) begin
      m = c % 18;
      e = (m < 8) ? 0 : (m < 10) ? 1 : (m == 10) ? 2 : (m < 15) ? 4 : (m < 17) ? 5 : 6;
      @(negedge clk);
      chk++; if (phase !== 3'(e)) $display("FAIL side_phase c=%0d got=%0d exp=%0d", c, phase, e); else pass++;
      chk++; if (main_lights !== exp_main(e) || side_lights !== exp_side(e) || walk !== 1'b0)
        $display("FAIL side_lamps c=%0d main=%b side=%b walk=%b exp %b/%b/0", c, main_lights, side_lights, walk, exp_main(e), exp_side(e));
      else pass++;
      next_cycle();
    end
  endtask

  // Pedestrian-only cycle; optional second press lands inside the walk phase.
  task automatic test_ped(input bit press_in_walk);
    int e;
    logic ep;
    start();
    for (int c = 0; c <= 30; c++) begin
      ped_button = (c == 2) || (press_in_walk && c == 13);
      e  = (c < 8) ? 0 : (c < 10) ? 1 : (c == 10) ? 2 : (c < 16) ? 3 : (c == 16) ? 6 : 0;
      ep = (c >= 3 && c <= 10);
      @(negedge clk);
      chk++; if (phase !== 3'(e)) $display("FAIL ped_phase c=%0d got=%0d exp=%0d", c, phase, e); else pass++;
      chk++; if (ped_pending !== ep) $display("FAIL ped_pending c=%0d got=%b exp=%b", c, ped_pending, ep); else pass++;
      chk++; if (walk !== (e == 3) || main_lights !== exp_main(e) || side_lights !== exp_side(e))
        $display("FAIL ped_lamps c=%0d walk=%b main=%b side=%b", c, walk, main_lights, side_lights);
      else pass++;
      next_cycle();
    end
    ped_button = 1'b0;
  endtask

  task automatic test_both();
    int e;
    logic ep;
    start();
    side_sensor = 1'b1;
    for (int c = 0; c <= 23; c++) begin
      ped_button = (c == 1);
      e  = (c < 8) ? 0 : (c < 10) ? 1 : (c == 10) ? 2 : (c < 16) ? 3 :
           (c < 20) ? 4 : (c < 22) ? 5 : (c == 22) ? 6 : 0;
      ep = (c >= 2 && c <= 10);
      @(negedge clk);
      chk++; if (phase !== 3'(e)) $display("FAIL both_phase c=%0d got=%0d exp=%0d", c, phase, e); else pass++;
      chk++; if (ped_pending !== ep) $display("FAIL both_pending c=%0d got=%b exp=%b", c, ped_pending, ep); else pass++;
      chk++; if (walk !== (e == 3) || main_lights !== exp_main(e) || side_lights !== exp_side(e))
        $display("FAIL both_lamps c=%0d walk=%b main=%b side=%b", c, walk, main_lights, side_lights);
      else pass++;
      next_cycle();
    end
    ped_button = 1'b0;
  endtask

  task automatic test_late_demand();
    int e;
    start();
    for (int c = 0; c <= 26; c++) begin
      side_sensor = (c >= 20);
      e = (c < 21) ? 0 : (c < 23) ? 1 : (c == 23) ? 2 : 4;
      @(negedge clk);
      chk++; if (phase !== 3'(e)) $display("FAIL late_phase c=%0d got=%0d exp=%0d", c, phase, e); else pass++;
      next_cycle();
    end
    side_sensor = 1'b0;
  endtask

  task automatic test_async_reset();
    start();
    side_sensor = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      ped_button = (c == 12);
      @(negedge clk);
      if (c == 13) begin
        chk++; if (phase !== 3'd4 || ped_pending !== 1'b1)
          $display("FAIL arst_pre phase=%0d pending=%b exp 4/1", phase, ped_pending);
        else pass++;
      end else next_cycle();
    end
    ped_button = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk++; if (main_lights !== 3'b001 || side_lights !== 3'b100 || walk !== 1'b0 ||
               ped_pending !== 1'b0 || phase !== 3'd0)
      $display("FAIL arst_now main=%b side=%b walk=%b pend=%b phase=%0d exp 001/100/0/0/0",
               main_lights, side_lights, walk, ped_pending, phase);
    else pass++;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      chk++; if (phase !== ((c < 8) ? 3'd0 : 3'd1))
        $display("FAIL arst_regreen c=%0d got=%0d exp=%0d", c, phase, (c < 8) ? 0 : 1);
      else pass++;
      next_cycle();
    end
    side_sensor = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ped_button = 1'b0; side_sensor = 1'b0;
    test_reset();
    test_idle();
    test_side_demand();
    test_ped(1'b0);
    test_both();
    test_late_demand();
    test_ped(1'b1);
    test_async_reset();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
